// File: rtl/huffman_pkg.sv
// Shared types, width helpers and default parameter values for the streaming Huffman encoder.
package huffman_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        LAST  = 2'd2
    } enc_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'(1) << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

    localparam int unsigned DEF_SYMBOL_W     = 8;
    localparam int unsigned DEF_MAX_CODE_LEN = 16;
    localparam int unsigned DEF_OUTPUT_W     = 32;

    localparam int unsigned LEN_W  = clog2(DEF_MAX_CODE_LEN + 1);
    localparam int unsigned ACC_W  = DEF_OUTPUT_W + DEF_MAX_CODE_LEN;
    localparam int unsigned FILL_W = clog2(ACC_W + 1);
    localparam int unsigned CNT_W  = clog2(DEF_OUTPUT_W + 1);

endpackage

// File: rtl/huffman_bit_packer.sv
// Left-aligned bit accumulator: appends variable-length codes and emits fixed-width words MSB first.
module huffman_bit_packer
    import huffman_pkg::*;
#(
    parameter  int unsigned maxCodeLength = DEF_MAX_CODE_LEN,
    parameter  int unsigned outputWidth   = DEF_OUTPUT_W,
    localparam int unsigned LENGTH_W      = clog2(maxCodeLength + 1),
    localparam int unsigned ACCUM_W       = outputWidth + maxCodeLength,
    localparam int unsigned FILLCNT_W     = clog2(ACCUM_W + 1),
    localparam int unsigned BITCNT_W      = clog2(outputWidth + 1)
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     append_i,
    input  logic [maxCodeLength-1:0] code_i,
    input  logic [LENGTH_W-1:0]      length_i,
    input  logic                     last_mode_i,
    input  logic                     out_ready_i,
    output logic                     out_valid_o,
    output logic [outputWidth-1:0]   out_data_o,
    output logic [BITCNT_W-1:0]      out_bit_count_o,
    output logic                     out_last_o,
    output logic [FILLCNT_W-1:0]     fill_count_o
);

    logic [ACCUM_W-1:0]   acc_q, acc_d;
    logic [FILLCNT_W-1:0] fill_q, fill_d;
    logic [FILLCNT_W-1:0] shamt;
    logic                 word_full;
    logic                 fire;

    assign word_full   = fill_q >= FILLCNT_W'(outputWidth);
    assign out_valid_o = word_full || last_mode_i;
    assign fire        = out_valid_o && out_ready_i;
    // New code lands directly below the bits already held.
    assign shamt       = FILLCNT_W'(ACCUM_W) - fill_q - FILLCNT_W'(length_i);

    always_comb begin : pack_next
        acc_d  = acc_q;
        fill_d = fill_q;
        if (fire && last_mode_i) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (fire) begin
            acc_d  = acc_q << outputWidth;
            fill_d = fill_q - FILLCNT_W'(outputWidth);
        end else if (append_i) begin
            acc_d  = acc_q | (ACCUM_W'(code_i) << shamt);
            fill_d = fill_q + FILLCNT_W'(length_i);
        end
    end

    always_ff @(posedge clock) begin : pack_reg
        if (!resetN) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign out_data_o      = acc_q[ACCUM_W-1 -: outputWidth];
    assign out_bit_count_o = last_mode_i ? BITCNT_W'(fill_q)
                           : (word_full ? BITCNT_W'(outputWidth) : '0);
    assign out_last_o      = last_mode_i;
    assign fill_count_o    = fill_q;

endmodule

// File: rtl/huffman_stream_encoder.sv
// Streaming Huffman encoder: run-time code table, RUN/FLUSH/LAST control and sticky error around the bit packer.
module huffman_stream_encoder
    import huffman_pkg::*;
#(
    parameter  int unsigned symbolWidth   = DEF_SYMBOL_W,
    parameter  int unsigned maxCodeLength = DEF_MAX_CODE_LEN,
    parameter  int unsigned outputWidth   = DEF_OUTPUT_W,
    localparam int unsigned LENGTH_W      = clog2(maxCodeLength + 1),
    localparam int unsigned ACCUM_W       = outputWidth + maxCodeLength,
    localparam int unsigned FILLCNT_W     = clog2(ACCUM_W + 1),
    localparam int unsigned BITCNT_W      = clog2(outputWidth + 1),
    localparam int unsigned DEPTH         = 2 ** symbolWidth,
    localparam int unsigned MASK_W        = maxCodeLength + 1
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     tableWrite,
    input  logic [symbolWidth-1:0]   tableSymbol,
    input  logic [maxCodeLength-1:0] tableCode,
    input  logic [LENGTH_W-1:0]      tableLength,
    input  logic                     symbolValid,
    output logic                     symbolReady,
    input  logic [symbolWidth-1:0]   symbol,
    input  logic                     flush,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [outputWidth-1:0]   outData,
    output logic [BITCNT_W-1:0]      outBitCount,
    output logic                     outLast,
    output logic                     flushDone,
    output logic                     error
);

    enc_state_e                 state_q, state_d;
    logic [maxCodeLength-1:0]   code_q [DEPTH];
    logic [LENGTH_W-1:0]        len_q  [DEPTH];
    logic                       ready_en_q;
    logic                       error_q, error_d;
    logic                       flush_done_q, flush_done_d;
    logic                       accept;
    logic                       write_ok, write_bad;
    logic [MASK_W-1:0]          mask;
    logic [maxCodeLength-1:0]   code_masked;
    logic [maxCodeLength-1:0]   lut_code;
    logic [LENGTH_W-1:0]        lut_len;
    logic [FILLCNT_W-1:0]       fill;
    logic                       word_full;

    assign write_bad   = tableWrite && (tableLength > LENGTH_W'(maxCodeLength));
    assign write_ok    = tableWrite && !write_bad;
    assign mask        = (MASK_W'(1) << tableLength) - MASK_W'(1);
    assign code_masked = maxCodeLength'({1'b0, tableCode} & mask);
    assign lut_code    = code_q[symbol];
    assign lut_len     = len_q[symbol];
    assign word_full   = fill >= FILLCNT_W'(outputWidth);

    // Codes are never read while their length is zero, so they need no reset.
    always_ff @(posedge clock) begin : table_code
        if (write_ok) begin
            code_q[tableSymbol] <= code_masked;
        end
    end

    always_ff @(posedge clock) begin : table_len
        if (!resetN) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                len_q[i] <= '0;
            end
        end else if (write_ok) begin
            len_q[tableSymbol] <= tableLength;
        end
    end

    always_ff @(posedge clock) begin : state_reg
        if (!resetN) begin
            state_q      <= RUN;
            ready_en_q   <= 1'b0;
            error_q      <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            error_q      <= error_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            RUN:     if (flush) state_d = FLUSH;
            FLUSH:   if (!word_full) state_d = (fill != '0) ? LAST : RUN;
            LAST:    if (outReady) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin : outputs
        symbolReady  = 1'b0;
        accept       = 1'b0;
        flush_done_d = 1'b0;
        error_d      = error_q;
        symbolReady  = ready_en_q && (state_q == RUN) && !word_full && !tableWrite && !flush;
        accept       = symbolValid && symbolReady;
        flush_done_d = ((state_q == FLUSH) && !word_full && (fill == '0))
                    || ((state_q == LAST) && outReady);
        error_d      = error_q || write_bad || (accept && (lut_len == '0));
    end

    assign flushDone = flush_done_q;
    assign error     = error_q;

    huffman_bit_packer #(
        .maxCodeLength (maxCodeLength),
        .outputWidth   (outputWidth)
    ) u_packer (
        .clock           (clock),
        .resetN          (resetN),
        .append_i        (accept && (lut_len != '0)),
        .code_i          (lut_code),
        .length_i        (lut_len),
        .last_mode_i     (state_q == LAST),
        .out_ready_i     (outReady),
        .out_valid_o     (outValid),
        .out_data_o      (outData),
        .out_bit_count_o (outBitCount),
        .out_last_o      (outLast),
        .fill_count_o    (fill)
    );

endmodule

// File: tb/tb_huffman_stream_encoder.sv
// Directed self-checking bench for huffman_stream_encoder with default parameters.
module tb_huffman_stream_encoder;
    import huffman_pkg::*;

    localparam int unsigned SW = 8;
    localparam int unsigned ML = 16;
    localparam int unsigned OW = 32;
    localparam int unsigned LW = clog2(ML + 1);
    localparam int unsigned CW = clog2(OW + 1);

    logic          clock = 1'b0;
    logic          resetN = 1'b0;
    logic          tableWrite = 1'b0;
    logic [SW-1:0] tableSymbol = '0;
    logic [ML-1:0] tableCode = '0;
    logic [LW-1:0] tableLength = '0;
    logic          symbolValid = 1'b0;
    logic          symbolReady;
    logic [SW-1:0] symbol = '0;
    logic          flush = 1'b0;
    logic          outValid;
    logic          outReady = 1'b0;
    logic [OW-1:0] outData;
    logic [CW-1:0] outBitCount;
    logic          outLast;
    logic          flushDone;
    logic          error;

    int checks = 0;
    int errors = 0;

    huffman_stream_encoder dut (
        .clock       (clock),
        .resetN      (resetN),
        .tableWrite  (tableWrite),
        .tableSymbol (tableSymbol),
        .tableCode   (tableCode),
        .tableLength (tableLength),
        .symbolValid (symbolValid),
        .symbolReady (symbolReady),
        .symbol      (symbol),
        .flush       (flush),
        .outValid    (outValid),
        .outReady    (outReady),
        .outData     (outData),
        .outBitCount (outBitCount),
        .outLast     (outLast),
        .flushDone   (flushDone),
        .error       (error)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetN = 1'b0; symbolValid = 1'b0; flush = 1'b0; tableWrite = 1'b0; outReady = 1'b0;
        step(); step();
        resetN = 1'b1;
        step();
    endtask

    task automatic load(input logic [SW-1:0] s, input logic [ML-1:0] c, input logic [LW-1:0] l);
        tableWrite = 1'b1; tableSymbol = s; tableCode = c; tableLength = l;
        step();
        tableWrite = 1'b0;
    endtask

    task automatic send(input logic [SW-1:0] s);
        int n;
        symbolValid = 1'b1; symbol = s;
        #1;
        n = 0;
        while (!symbolReady && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout symbol=%h ready never rose", s);
        end
        step();
        symbolValid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_last(output bit ok);
        int n;
        n = 0;
        while (!(outValid && outLast) && n < 20) begin
            step();
            n++;
        end
        ok = outValid && outLast;
    endtask

    task automatic test_reset();
        resetN = 1'b0; symbolValid = 1'b1; symbol = 8'h41;
        repeat (3) step();
        checks++; if (symbolReady !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", symbolReady); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_outValid got %b want 0", outValid); end
        checks++; if (outData !== 32'h0) begin errors++; $display("FAIL rst_outData got %h want 0", outData); end
        checks++; if (outBitCount !== 6'd0) begin errors++; $display("FAIL rst_bitcount got %0d want 0", outBitCount); end
        checks++; if (outLast !== 1'b0) begin errors++; $display("FAIL rst_outLast got %b want 0", outLast); end
        checks++; if (flushDone !== 1'b0) begin errors++; $display("FAIL rst_flushDone got %b want 0", flushDone); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
        resetN = 1'b1; symbolValid = 1'b0;
        step();
        checks++; if (symbolReady !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b want 1", symbolReady); end
    endtask

    task automatic test_basic_pack();
        bit ok;
        load(8'h41, 16'h0000, 5'd1);
        load(8'h42, 16'h0002, 5'd2);
        load(8'h43, 16'hFFF3, 5'd2);
        outReady = 1'b0;
        send(8'h41); send(8'h42); send(8'h43); send(8'h41);
        pulse_flush();
        wait_last(ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_last_timeout outValid=%b outLast=%b", outValid, outLast); end
        checks++; if (outData !== 32'h58000000) begin errors++; $display("FAIL basic_data got %h want 58000000", outData); end
        checks++; if (outBitCount !== 6'd6) begin errors++; $display("FAIL basic_bitcount got %0d want 6", outBitCount); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b want 0", error); end
        outReady = 1'b1;
        step();
        checks++; if (flushDone !== 1'b1) begin errors++; $display("FAIL basic_flushDone got %b want 1", flushDone); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got %b want 0", outValid); end
        outReady = 1'b0;
        step();
        checks++; if (flushDone !== 1'b0) begin errors++; $display("FAIL basic_flushDone_pulse got %b want 0", flushDone); end
    endtask

    task automatic test_full_word();
        outReady = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h42);
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL full_valid got %b want 1", outValid); end
        checks++; if (outData !== 32'hAAAAAAAA) begin errors++; $display("FAIL full_data got %h want aaaaaaaa", outData); end
        checks++; if (outBitCount !== 6'd32) begin errors++; $display("FAIL full_bitcount got %0d want 32", outBitCount); end
        checks++; if (outLast !== 1'b0) begin errors++; $display("FAIL full_last got %b want 0", outLast); end
        checks++; if (symbolReady !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", symbolReady); end
    endtask

    task automatic test_backpressure();
        bit ok;
        symbolValid = 1'b1; symbol = 8'h41;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (outData !== 32'hAAAAAAAA || symbolReady !== 1'b0 || outValid !== 1'b1) begin
                errors++;
                $display("FAIL stall_cycle%0d data=%h ready=%b valid=%b want aaaaaaaa/0/1", i, outData, symbolReady, outValid);
            end
            step();
        end
        outReady = 1'b1;
        send(8'h41);
        outReady = 1'b0;
        send(8'h43);
        pulse_flush();
        wait_last(ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_last_timeout outValid=%b", outValid); end
        checks++; if (outData !== 32'h60000000) begin errors++; $display("FAIL bp_data got %h want 60000000", outData); end
        checks++; if (outBitCount !== 6'd3) begin errors++; $display("FAIL bp_bitcount got %0d want 3", outBitCount); end
        outReady = 1'b1;
        step();
        outReady = 1'b0;
        checks++; if (flushDone !== 1'b1) begin errors++; $display("FAIL bp_flushDone got %b want 1", flushDone); end
    endtask

    task automatic test_unloaded_symbol();
        bit saw_valid, saw_done;
        send(8'h7F);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL unloaded_error got %b want 1", error); end
        pulse_flush();
        saw_valid = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (outValid) saw_valid = 1'b1;
            if (flushDone) saw_done = 1'b1;
            step();
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL unloaded_no_bits got valid=%b want 0", saw_valid); end
        checks++; if (saw_done !== 1'b1) begin errors++; $display("FAIL unloaded_flushDone got %b want 1", saw_done); end
    endtask

    task automatic test_bad_write();
        bit ok;
        do_reset();
        load(8'h41, 16'h0000, 5'd1);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL badwr_pre_error got %b want 0", error); end
        load(8'h41, 16'hFFFF, 5'd17);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badwr_error got %b want 1", error); end
        send(8'h41);
        pulse_flush();
        wait_last(ok);
        checks++; if (!ok) begin errors++; $display("FAIL badwr_last_timeout outValid=%b", outValid); end
        checks++; if (outData !== 32'h0 || outBitCount !== 6'd1) begin
            errors++; $display("FAIL badwr_entry_kept got %h/%0d want 00000000/1", outData, outBitCount);
        end
        outReady = 1'b1;
        step();
        outReady = 1'b0;
    endtask

    task automatic test_empty_flush();
        bit saw_valid, saw_done;
        do_reset();
        pulse_flush();
        saw_valid = 1'b0; saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (outValid) saw_valid = 1'b1;
            if (flushDone) saw_done = 1'b1;
            step();
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b want 0", saw_valid); end
        checks++; if (saw_done !== 1'b1) begin errors++; $display("FAIL empty_flushDone got %b want 1", saw_done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL empty_error got %b want 0", error); end
    endtask

    task automatic test_reset_in_last();
        bit ok;
        do_reset();
        load(8'h41, 16'h0000, 5'd1);
        send(8'h41); send(8'h41);
        pulse_flush();
        wait_last(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rlast_reach got valid=%b last=%b want 1/1", outValid, outLast); end
        resetN = 1'b0;
        step();
        checks++; if (outValid !== 1'b0 || outLast !== 1'b0) begin
            errors++; $display("FAIL rlast_valid got %b/%b want 0/0", outValid, outLast);
        end
        checks++; if (outData !== 32'h0 || outBitCount !== 6'd0) begin
            errors++; $display("FAIL rlast_data got %h/%0d want 0/0", outData, outBitCount);
        end
        resetN = 1'b1;
        step();
        send(8'h41);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL rlast_table_cleared error=%b want 1", error); end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_full_word();
        test_backpressure();
        test_unloaded_symbol();
        test_bad_write();
        test_empty_flush();
        test_reset_in_last();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
